// File: rtl/pc_gen_pkg.sv
// Shared encodings and default addresses for the fetch-stage PC unit.
package pc_gen_pkg;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6FFC;

endpackage

// File: rtl/pc_gen_npc.sv
// Combinational next-PC selector: control-flow target and whether the
// current instruction redirects fetch at all.
module npc_calc
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       npc_op,
  input  logic             br_ok,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] ctl_pc,
  output logic             ctl_redirect
);

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] j_tgt;

  assign pc_seq = pc + WIDTH'(4);
  assign br_off = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};

  // A 28-bit datapath has no upper region bits left to keep for j/jal.
  if (WIDTH > 28) begin : g_jhi
    assign j_tgt = {pc[WIDTH-1:28], imm26, 2'b00};
  end else begin : g_jlo
    assign j_tgt = {imm26, 2'b00};
  end

  // Target selection; a not-taken branch still counts as a redirect.
  always_comb begin
    ctl_pc       = pc_seq;
    ctl_redirect = 1'b0;
    case (npc_op)
      NPC_BR: begin
        ctl_pc       = br_ok ? (pc + br_off) : pc_seq;
        ctl_redirect = 1'b1;
      end
      NPC_J: begin
        ctl_pc       = j_tgt;
        ctl_redirect = 1'b1;
      end
      NPC_JR: begin
        ctl_pc       = ra;
        ctl_redirect = 1'b1;
      end
      default: begin
        ctl_pc       = pc_seq;
        ctl_redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with exception/eret redirect, a pending-redirect latch
// that survives stalls, fetch address-error flag and issued-fetch counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] HANDLER_PC = WIDTH'(DEF_HANDLER_PC),
  parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(DEF_IMEM_LO),
  parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(DEF_IMEM_HI),
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic             br_ok,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] ra,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] F_pc,
  output logic             F_adel,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [WIDTH-1:0] ctl_pc;
  logic             ctl_redirect;
  logic [WIDTH-1:0] pc_d;
  logic             pend_v, pend_v_d;
  logic [WIDTH-1:0] pend_pc, pend_pc_d;
  logic             pc_wr;

  npc_calc #(.WIDTH(WIDTH)) u_npc (
    .pc           (F_pc),
    .npc_op       (npc_op),
    .br_ok        (br_ok),
    .imm26        (imm26),
    .ra           (ra),
    .ctl_pc       (ctl_pc),
    .ctl_redirect (ctl_redirect)
  );

  // Next-PC priority: exception, eret, stall (latch redirect), live
  // redirect, pending redirect, sequential.
  always_comb begin
    pc_d      = F_pc;
    pend_v_d  = pend_v;
    pend_pc_d = pend_pc;
    pc_wr     = 1'b1;
    if (exc_req) begin
      pc_d     = HANDLER_PC;
      pend_v_d = 1'b0;
    end else if (eret_req) begin
      pc_d     = epc;
      pend_v_d = 1'b0;
    end else if (stall) begin
      pc_wr = 1'b0;
      if (ctl_redirect) begin
        pend_v_d  = 1'b1;
        pend_pc_d = ctl_pc;
      end
    end else if (ctl_redirect) begin
      pc_d     = ctl_pc;
      pend_v_d = 1'b0;
    end else if (pend_v) begin
      pc_d     = pend_pc;
      pend_v_d = 1'b0;
    end else begin
      pc_d = F_pc + WIDTH'(4);
    end
  end

  // State registers; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc      <= RESET_PC;
      pend_v    <= 1'b0;
      pend_pc   <= '0;
      fetch_cnt <= '0;
    end else begin
      F_pc    <= pc_d;
      pend_v  <= pend_v_d;
      pend_pc <= pend_pc_d;
      if (pc_wr) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

  // Address error is only flagged; the exception path decides whether to trap.
  assign F_adel = (F_pc[1:0] != 2'b00) | (F_pc < IMEM_LO) | (F_pc > IMEM_HI);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver pushes model predictions, monitor
// pops and compares one cycle later.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, br_ok, exc_req, eret_req;
  logic [2:0]  npc_op;
  logic [25:0] imm26;
  logic [31:0] ra, epc;
  logic [31:0] F_pc;
  logic        F_adel;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  longint unsigned m_pc, m_ppc, m_cnt;
  bit              m_pv;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_ok(br_ok),
    .imm26(imm26), .ra(ra), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .F_pc(F_pc), .F_adel(F_adel), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit ref_adel(longint unsigned pc);
    return (pc % 4 != 0) || (pc < 64'h3000) || (pc > 64'h6FFC);
  endfunction

  function automatic void check(string name, longint unsigned act, longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // One cycle of stimulus: apply inputs, advance the model, queue the prediction.
  task automatic drive(input bit rst, input bit stl, input logic [2:0] op, input bit bok,
                       input logic [25:0] imm, input logic [31:0] r, input bit ex,
                       input bit er, input logic [31:0] e);
    longint unsigned tgt;
    bit              redir;
    longint signed   off;
    exp_t            x;
    @(negedge clk);
    reset = rst; stall = stl; npc_op = op; br_ok = bok; imm26 = imm; ra = r;
    exc_req = ex; eret_req = er; epc = e;
    off   = longint'($signed(imm[15:0])) * 4;
    redir = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    case (op)
      3'd1:    tgt = bok ? (m_pc + off) % 64'h1_0000_0000 : (m_pc + 4) % 64'h1_0000_0000;
      3'd2:    tgt = (m_pc / 64'h1000_0000) * 64'h1000_0000 + longint'(imm) * 4;
      3'd3:    tgt = r;
      default: tgt = (m_pc + 4) % 64'h1_0000_0000;
    endcase
    if (rst) begin
      m_pc = 64'h3000; m_pv = 0; m_ppc = 0; m_cnt = 0;
    end else begin
      if (ex || er || !stl) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
      if (ex) begin m_pc = 64'h4180; m_pv = 0; end
      else if (er) begin m_pc = e; m_pv = 0; end
      else if (stl) begin if (redir) begin m_pv = 1; m_ppc = tgt; end end
      else if (redir) begin m_pc = tgt; m_pv = 0; end
      else if (m_pv) begin m_pc = m_ppc; m_pv = 0; end
      else m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end
    x.pc = 32'(m_pc); x.adel = ref_adel(m_pc); x.cnt = 32'(m_cnt);
    sbq.push_back(x);
  endtask

  task automatic idle(); drive(0, 0, 3'd0, 0, 26'd0, 32'd0, 0, 0, 32'd0); endtask
  task automatic jr(input logic [31:0] t, input bit stl);
    drive(0, stl, 3'd3, 0, 26'd0, t, 0, 0, 32'd0);
  endtask

  // Directed check of DUT outputs just after the edge that consumed the last drive.
  task automatic expect_now(string name, logic [31:0] pc, logic adel);
    @(posedge clk); #2;
    check({name, "_pc"}, F_pc, pc);
    check({name, "_adel"}, F_adel, adel);
  endtask

  // Monitor: every cycle the DUT presents a new F_pc; compare with the queue head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        check("sb_pc", F_pc, x.pc);
        check("sb_adel", F_adel, x.adel);
        check("sb_cnt", fetch_cnt, x.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c0;
    reset = 1; stall = 0; npc_op = 0; br_ok = 0; imm26 = 0; ra = 0;
    exc_req = 0; eret_req = 0; epc = 0;
    m_pc = 64'h3000; m_pv = 0; m_ppc = 0; m_cnt = 0;

    drive(1, 0, 3'd0, 0, 26'd0, 32'd0, 0, 0, 32'd0);
    drive(1, 0, 3'd0, 0, 26'd0, 32'd0, 0, 0, 32'd0);
    expect_now("reset", 32'h3000, 0);
    check("reset_cnt", fetch_cnt, 0);
    idle(); expect_now("idle1", 32'h3004, 0);
    idle(); expect_now("idle2", 32'h3008, 0);
    idle(); expect_now("idle3", 32'h300C, 0);
    check("idle_cnt", fetch_cnt, 3);

    idle();                                                    // 0x3010
    drive(0, 0, 3'd1, 1, 26'h000FFFE, 32'd0, 0, 0, 32'd0);
    expect_now("br_taken", 32'h3008, 0);
    jr(32'h3010, 0);
    drive(0, 0, 3'd1, 0, 26'h000FFFE, 32'd0, 0, 0, 32'd0);
    expect_now("br_not", 32'h3014, 0);

    jr(32'h3020, 0);
    expect_now("pre_stall", 32'h3020, 0);
    c0 = fetch_cnt;
    jr(32'h3400, 1);
    expect_now("stall1", 32'h3020, 0);
    drive(0, 1, 3'd0, 0, 26'd0, 32'd0, 0, 0, 32'd0);
    expect_now("stall2", 32'h3020, 0);
    check("stall_cnt", fetch_cnt, c0);
    idle(); expect_now("pend_take", 32'h3400, 0);

    jr(32'h3500, 1);
    drive(0, 1, 3'd0, 0, 26'd0, 32'd0, 1, 1, 32'h3044);
    expect_now("exc_wins", 32'h4180, 0);
    drive(0, 0, 3'd0, 0, 26'd0, 32'd0, 0, 1, 32'h3044);
    expect_now("eret", 32'h3044, 0);
    idle(); expect_now("pend_cleared", 32'h3048, 0);

    jr(32'h3002, 0); expect_now("adel_unal", 32'h3002, 1);
    jr(32'h7000, 0); expect_now("adel_hi", 32'h7000, 1);
    jr(32'h6FFC, 0); expect_now("adel_top", 32'h6FFC, 0);
    jr(32'h2FFC, 0); expect_now("adel_lo", 32'h2FFC, 1);

    jr(32'h3600, 1);
    drive(1, 1, 3'd0, 0, 26'd0, 32'd0, 0, 0, 32'd0);
    expect_now("rst_pend", 32'h3000, 0);
    idle(); expect_now("rst_nopend", 32'h3004, 0);

    jr(32'hFFFF_FFFC, 0);
    idle(); expect_now("wrap", 32'h0000_0000, 1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r, e;
      r = (32'h3000 + ($urandom_range(0, 32'hFFF) << 2));
      if ($urandom_range(0, 9) == 0) r = $urandom;
      e = (32'h3000 + ($urandom_range(0, 32'hFFF) << 2));
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)), 1'($urandom), 26'($urandom), r,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, e);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-stage program counter unit for the pipelined MIPS core: owns the F_PC register and computes the next PC.
- Generalises the combinational next-PC selector with parameterised width and addresses, exception/ERET redirect and a pending-redirect latch.
- The latch lets redirect pulses that arrive while fetch is stalled survive the stall.
- Also flags instruction-fetch address errors (AdEL) and counts issued fetches.

Parameters:
- WIDTH, 32, address/data width (at least 28; the jump concatenation uses PC[WIDTH-1:28])
- RESET_PC, 32'h0000_3000, PC after reset
- HANDLER_PC, 32'h0000_4180, exception entry address
- IMEM_LO, 32'h0000_3000, lowest legal fetch address
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address
- CNT_W, 32, fetch counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- stall  in  1  hold F_PC (hazard unit)
- npc_op  in  3  0 seq, 1 branch, 2 j/jal, 3 jr/jalr, others treated as seq
- br_ok  in  1  branch condition true (used only when npc_op=1)
- imm26  in  26  instr_index; imm26[15:0] is the branch offset
- ra  in  WIDTH  register jump target
- exc_req  in  1  exception taken this cycle
- eret_req  in  1  eret committing this cycle
- epc  in  WIDTH  EPC value for eret
- F_pc  out  WIDTH  current fetch PC
- F_adel  out  1  fetch address error on F_pc
- fetch_cnt  out  CNT_W  number of PCs issued since reset

Behaviour:
- Reset (synchronous, highest priority): F_pc=RESET_PC, pend_v=0, pend_pc=0, fetch_cnt=0. F_adel follows F_pc combinationally.
- Control target ctl_pc is combinational from the current-cycle inputs:
  - op1 with br_ok=1: F_pc + sign-extended(imm26[15:0])<<2.
  - op1 with br_ok=0: F_pc+4.
  - op2: {F_pc[WIDTH-1:28], imm26, 2'b00}.
  - op3: ra.
  - op0, op4-7: F_pc+4.
  - ctl_redirect=1 for op1 (either outcome), op2 and op3.
- Arithmetic is modulo 2^WIDTH; F_pc+4 at 32'hFFFF_FFFC wraps to 0.
- Per-cycle next-state priority:
  1. reset.
  2. exc_req: F_pc<=HANDLER_PC, pend_v<=0. Ignores stall and exc_req wins over eret_req.
  3. eret_req: F_pc<=epc, pend_v<=0. Ignores stall.
  4. stall=1: F_pc holds. If ctl_redirect, pend_v<=1 and pend_pc<=ctl_pc; a new redirect overwrites an existing pending one.
  5. stall=0 and ctl_redirect: F_pc<=ctl_pc, pend_v<=0. The current-cycle redirect beats a stale pending one.
  6. stall=0 and pend_v: F_pc<=pend_pc, pend_v<=0.
  7. Otherwise: F_pc<=F_pc+4.
- fetch_cnt increments by 1 on every non-reset cycle where F_pc is written (cases 2, 3, 5, 6, 7), wraps at 2^CNT_W, and holds on stall.
- F_adel = (F_pc[1:0]!=0) | (F_pc<IMEM_LO) | (F_pc>IMEM_HI).
  - The unit does not self-trap; the exception path decides and returns exc_req.
  - F_pc still advances as normal while F_adel=1.
- Latency: one cycle from any request to F_pc update.
- Reset asserted mid-stall or with a pending redirect discards all state.

Decomposition:
- Shared package holds:
  - npc_op encodings NPC_SEQ=0, NPC_BR=1, NPC_J=2, NPC_JR=3;
  - default RESET_PC, HANDLER_PC, IMEM_LO and IMEM_HI.
- The existing combinational next-PC selector is natural as sub-module npc_calc (produces ctl_pc and ctl_redirect).
- pc_gen wraps npc_calc with the register, the pending latch, the priority logic, the counter and the range check.

Test Plan:
- Reset then 3 idle cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt=3; F_adel=0.
- F_pc=0x3010, npc_op=1, br_ok=1, imm16=0xFFFE -> F_pc=0x3008 next cycle; with br_ok=0 -> 0x3014.
- F_pc=0x3020, stall=1 for 2 cycles with npc_op=3, ra=0x3400 in the first stall cycle only -> F_pc holds at 0x3020 (fetch_cnt holds), then 0x3400 on the first unstalled cycle.
- exc_req=1 and eret_req=1 together while stall=1 and pend_v=1 -> F_pc=0x4180, pend_v cleared; next cycle eret_req=1, epc=0x3044 -> F_pc=0x3044.
- npc_op=3, ra=0x3002 -> F_adel=1 next cycle; ra=0x7000 -> F_adel=1; ra=0x6FFC -> F_adel=0.
- reset asserted while pend_v=1 -> F_pc=0x3000, pend_v=0 and the pending target is never fetched after release.
